// File: rtl/snake_pkg.sv
// Shared definitions for the snake body engine.
//   - direction encoding (up/right/down/left)
//   - move FSM state enum
//   - default grid geometry
//   - grid coordinate struct {x, y}
//   - dir_opposite(): the direction that would reverse a given direction
package snake_pkg;

  localparam int GRID_W_DEF  = 32;
  localparam int GRID_H_DEF  = 24;
  localparam int COORD_X_W   = 5;
  localparam int COORD_Y_W   = 5;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    SCAN   = 3'd2,
    COMMIT = 3'd3,
    DEAD   = 3'd4
  } state_t;

  typedef struct packed {
    logic [COORD_X_W-1:0] x;
    logic [COORD_Y_W-1:0] y;
  } coord_t;

  // Encoding is chosen so that opposite directions differ by two.
  function automatic logic [1:0] dir_opposite(input logic [1:0] d);
    return d + 2'd2;
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head generator with wrap-around at the grid edges.
// Ports:
//   head_x, head_y : current head coordinate
//   dir            : direction of travel (snake_pkg DIR_* encoding)
//   next_x, next_y : head after one cell of travel, wrapped into the grid
module snake_next_head
  import snake_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter int X_W    = 5,
  parameter int Y_W    = 5
) (
  input  logic [X_W-1:0] head_x,
  input  logic [Y_W-1:0] head_y,
  input  logic [1:0]     dir,
  output logic [X_W-1:0] next_x,
  output logic [Y_W-1:0] next_y
);

  localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);

  // Grid sizes need not be powers of two, so the edges are compared
  // explicitly rather than relying on natural counter overflow.
  always_comb begin
    next_x = head_x;
    next_y = head_y;
    case (dir)
      DIR_UP:    next_y = (head_y == '0)    ? Y_MAX : head_y - 1'b1;
      DIR_RIGHT: next_x = (head_x == X_MAX) ? '0    : head_x + 1'b1;
      DIR_DOWN:  next_y = (head_y == Y_MAX) ? '0    : head_y + 1'b1;
      DIR_LEFT:  next_x = (head_x == '0)    ? X_MAX : head_x - 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body engine: stores the snake as a circular buffer of grid cells,
// performs one move per step request (new head, self-collision scan, commit)
// and offers a registered random-access read port for the renderer.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   step, dir, grow   : move request, requested direction, extend-on-move
//   restart           : synchronous return to the reset state
//   busy, done        : move in progress / one-cycle completion pulse
//   collide           : sticky self-collision flag
//   head_x, head_y    : current head cell
//   len               : current length (1..MAX_LEN)
//   rd_idx            : segment to read (0 = tail, len-1 = head)
//   rd_x, rd_y        : segment cell, one cycle after rd_idx
//   rd_valid          : rd_idx was below len
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF,
  parameter int X_W     = 5,
  parameter int Y_W     = 5,
  parameter int MAX_LEN = 64,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic [1:0]       dir,
  input  logic             grow,
  input  logic             restart,
  output logic             busy,
  output logic             done,
  output logic             collide,
  output logic [X_W-1:0]   head_x,
  output logic [Y_W-1:0]   head_y,
  output logic [IDX_W:0]   len,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [X_W-1:0]   rd_x,
  output logic [Y_W-1:0]   rd_y,
  output logic             rd_valid
);

  localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(MAX_LEN);
  localparam logic [IDX_W:0] LEN_ONE = (IDX_W+1)'(1);

  // Circular-buffer pointer addition for operands already below MAX_LEN.
  function automatic logic [IDX_W-1:0] ptr_add(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= LEN_MAX) s = s - LEN_MAX;
    return s[IDX_W-1:0];
  endfunction

  logic [X_W-1:0]   body_x [MAX_LEN];
  logic [Y_W-1:0]   body_y [MAX_LEN];

  state_t           state;
  logic [IDX_W-1:0] head_ptr;
  logic [IDX_W-1:0] tail_ptr;
  logic [IDX_W:0]   len_q;
  logic [IDX_W:0]   scan_idx;
  logic [1:0]       last_dir;
  logic [1:0]       eff_dir;
  logic             grow_l;
  logic             hit;
  logic             busy_q;
  logic             done_q;
  logic             collide_q;

  logic [X_W-1:0]   new_x;
  logic [Y_W-1:0]   new_y;
  logic [X_W-1:0]   calc_x;
  logic [Y_W-1:0]   calc_y;

  logic             clr;
  logic [IDX_W-1:0] scan_ptr;
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_ptr;
  logic             scan_hit;
  logic             commit_move;
  logic             rd_in_range;

  assign clr         = !rst_n || restart;
  assign head_x      = body_x[head_ptr];
  assign head_y      = body_y[head_ptr];
  assign len         = len_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign collide     = collide_q;

  assign scan_ptr    = ptr_add(tail_ptr, scan_idx[IDX_W-1:0]);
  assign wr_ptr      = ptr_add(head_ptr, IDX_W'(1));
  assign rd_ptr      = ptr_add(tail_ptr, rd_idx);
  assign rd_in_range = ({1'b0, rd_idx} < len_q);
  assign commit_move = (state == COMMIT) && !hit;

  // The tail cell is vacated by a non-growing move, so it cannot be hit.
  assign scan_hit = (body_x[scan_ptr] == new_x) && (body_y[scan_ptr] == new_y) &&
                    (grow_l || (scan_idx != '0));

  snake_next_head #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_next_head (
    .head_x (head_x),
    .head_y (head_y),
    .dir    (eff_dir),
    .next_x (calc_x),
    .next_y (calc_y)
  );

  // Move FSM: IDLE -> CALC -> SCAN (len cycles) -> COMMIT -> IDLE or DEAD.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      len_q     <= LEN_ONE;
      head_ptr  <= '0;
      tail_ptr  <= '0;
      last_dir  <= DIR_RIGHT;
      eff_dir   <= DIR_RIGHT;
      grow_l    <= 1'b0;
      hit       <= 1'b0;
      scan_idx  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (step) begin
            grow_l  <= grow;
            // A one-cell snake may turn back; a longer one may not.
            eff_dir <= ((dir == dir_opposite(last_dir)) && (len_q > LEN_ONE)) ?
                       last_dir : dir;
            busy_q  <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          scan_idx <= '0;
          hit      <= 1'b0;
          state    <= SCAN;
        end
        SCAN: begin
          if (scan_hit) hit <= 1'b1;
          // Full-length scan even after a hit keeps move latency fixed.
          if (scan_idx == len_q - LEN_ONE) state <= COMMIT;
          else                              scan_idx <= scan_idx + 1'b1;
        end
        COMMIT: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (hit) begin
            collide_q <= 1'b1;
            state     <= DEAD;
          end else begin
            head_ptr <= wr_ptr;
            if (grow_l && (len_q < LEN_MAX)) len_q    <= len_q + 1'b1;
            else                              tail_ptr <= ptr_add(tail_ptr, IDX_W'(1));
            last_dir <= eff_dir;
            state    <= IDLE;
          end
        end
        DEAD: begin
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Candidate head, held stable across the scan and commit.
  always_ff @(posedge clk) begin
    if (state == CALC) begin
      new_x <= calc_x;
      new_y <= calc_y;
    end
  end

  // Body storage: only the initial cell is defined by reset; the rest of
  // the buffer is always written before it falls inside [tail, head].
  always_ff @(posedge clk) begin
    if (clr) begin
      body_x[0] <= X_W'(GRID_W / 2);
      body_y[0] <= Y_W'(GRID_H / 2);
    end else if (commit_move) begin
      body_x[wr_ptr] <= new_x;
      body_y[wr_ptr] <= new_y;
    end
  end

  // Renderer read port; sampling the array here returns pre-commit
  // contents during the COMMIT cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_valid <= 1'b0;
      rd_x     <= '0;
      rd_y     <= '0;
    end else begin
      rd_valid <= rd_in_range;
      rd_x     <= rd_in_range ? body_x[rd_ptr] : '0;
      rd_y     <= rd_in_range ? body_y[rd_ptr] : '0;
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: directed scenarios plus a random walk,
// all checked against a queue-based model of the snake (index 0 = tail).
module tb_snake_body_engine;
  import snake_pkg::*;

  localparam int GW = 32;
  localparam int GH = 24;
  localparam int ML = 64;

  logic       clk = 1'b0;
  logic       rst_n, step, grow, restart;
  logic [1:0] dir;
  logic [5:0] rd_idx;
  logic       busy, done, collide, rd_valid;
  logic [4:0] head_x, head_y, rd_x, rd_y;
  logic [6:0] len;

  int checks = 0;
  int errors = 0;

  coord_t mbody[$];
  int     mlast;
  bit     mcol;

  always #5 clk = ~clk;

  snake_body_engine #(
    .GRID_W(GW), .GRID_H(GH), .X_W(5), .Y_W(5), .MAX_LEN(ML), .IDX_W(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .dir(dir), .grow(grow),
    .restart(restart), .busy(busy), .done(done), .collide(collide),
    .head_x(head_x), .head_y(head_y), .len(len), .rd_idx(rd_idx),
    .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid)
  );

  // ---------------- reference model ----------------
  function automatic void model_reset();
    coord_t c;
    c.x = 5'(GW / 2);
    c.y = 5'(GH / 2);
    mbody.delete();
    mbody.push_back(c);
    mlast = 1;
    mcol  = 1'b0;
  endfunction

  function automatic void model_move(input int d, input bit g);
    int eff, nx, ny, n;
    bit h;
    coord_t c;
    if (mcol) return;
    eff = d;
    if (mbody.size() > 1 && d == (mlast + 2) % 4) eff = mlast;
    nx = int'(mbody[$].x);
    ny = int'(mbody[$].y);
    case (eff)
      0: ny = (ny + GH - 1) % GH;
      1: nx = (nx + 1) % GW;
      2: ny = (ny + 1) % GH;
      default: nx = (nx + GW - 1) % GW;
    endcase
    h = 1'b0;
    n = mbody.size();
    for (int i = (g ? 0 : 1); i < n; i++)
      if (int'(mbody[i].x) == nx && int'(mbody[i].y) == ny) h = 1'b1;
    if (h) begin
      mcol = 1'b1;
    end else begin
      c.x = 5'(nx);
      c.y = 5'(ny);
      mbody.push_back(c);
      if (!(g && n < ML)) void'(mbody.pop_front());
      mlast = eff;
    end
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  // Issues one step and reports the cycle (step cycle = 0) in which done
  // was seen, or -1 if no done arrived within the bound.
  task automatic do_move(input int d, input bit g, output int cyc, output int exp_cyc);
    exp_cyc = mcol ? -1 : mbody.size() + 3;
    model_move(d, g);
    @(negedge clk);
    dir = 2'(d); grow = g; step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0; grow = 1'b0;
    cyc = -1;
    for (int k = 1; k <= ML + 10; k++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc = k + 1;
        break;
      end
    end
  endtask

  task automatic do_restart();
    @(negedge clk); restart = 1'b1;
    @(posedge clk); #1; restart = 1'b0;
    model_reset();
  endtask

  task automatic read_seg(input int i, output logic [4:0] x, output logic [4:0] y,
                          output logic v);
    @(negedge clk); rd_idx = 6'(i);
    @(posedge clk); #1;
    x = rd_x; y = rd_y; v = rd_valid;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; step = 1'b0; grow = 1'b0; restart = 1'b0; dir = 2'd0; rd_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || collide !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b collide=%b, want 0 0 0", busy, done, collide);
    end
    checks++;
    if (head_x !== 5'd16 || head_y !== 5'd12 || len !== 7'd1) begin
      errors++;
      $display("FAIL reset_head: (%0d,%0d) len %0d, want (16,12) len 1", head_x, head_y, len);
    end
    checks++;
    if (rd_valid !== 1'b0 || rd_x !== 5'd0 || rd_y !== 5'd0) begin
      errors++;
      $display("FAIL reset_rd: valid=%b (%0d,%0d), want 0 (0,0)", rd_valid, rd_x, rd_y);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single_step();
    int cyc, exp_cyc;
    logic [4:0] x, y;
    logic v;
    do_move(1, 1'b0, cyc, exp_cyc);
    checks++;
    if (cyc !== 4) begin
      errors++; $display("FAIL single_latency: done at %0d, want 4", cyc);
    end
    checks++;
    if (head_x !== 5'd17 || head_y !== 5'd12 || len !== 7'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_head: (%0d,%0d) len %0d busy %b, want (17,12) len 1 busy 0",
               head_x, head_y, len, busy);
    end
    read_seg(0, x, y, v);
    checks++;
    if (v !== 1'b1 || x !== 5'd17 || y !== 5'd12) begin
      errors++; $display("FAIL single_rd0: v=%b (%0d,%0d), want 1 (17,12)", v, x, y);
    end
    read_seg(1, x, y, v);
    checks++;
    if (v !== 1'b0 || x !== 5'd0 || y !== 5'd0) begin
      errors++; $display("FAIL single_rd1: v=%b (%0d,%0d), want 0 (0,0)", v, x, y);
    end
  endtask

  task automatic test_wrap();
    int cyc, exp_cyc;
    do_restart();
    for (int s = 1; s <= 17; s++) begin
      do_move(3, 1'b0, cyc, exp_cyc);
      checks++;
      if (head_x !== mbody[$].x || head_y !== 5'd12 || cyc !== exp_cyc) begin
        errors++;
        $display("FAIL wrap_x step %0d: (%0d,%0d) cyc %0d, want (%0d,12) cyc %0d",
                 s, head_x, head_y, cyc, mbody[$].x, exp_cyc);
      end
    end
    checks++;
    if (head_x !== 5'd31) begin
      errors++; $display("FAIL wrap_x_edge: x=%0d, want 31", head_x);
    end
    for (int s = 1; s <= 13; s++) do_move(0, 1'b0, cyc, exp_cyc);
    checks++;
    if (head_y !== 5'd23 || head_x !== 5'd31) begin
      errors++; $display("FAIL wrap_y_edge: (%0d,%0d), want (31,23)", head_x, head_y);
    end
  endtask

  task automatic test_grow();
    int cyc, exp_cyc;
    logic [4:0] x, y;
    logic v;
    do_restart();
    for (int s = 0; s < 4; s++) do_move(1, 1'b1, cyc, exp_cyc);
    checks++;
    if (len !== 7'd5 || head_x !== 5'd20) begin
      errors++; $display("FAIL grow_len: len %0d x %0d, want len 5 x 20", len, head_x);
    end
    for (int i = 0; i < 5; i++) begin
      read_seg(i, x, y, v);
      checks++;
      if (v !== 1'b1 || x !== 5'(16 + i) || y !== 5'd12) begin
        errors++;
        $display("FAIL grow_rd idx %0d: v=%b (%0d,%0d), want 1 (%0d,12)", i, v, x, y, 16 + i);
      end
    end
    do_move(1, 1'b1, cyc, exp_cyc);
    checks++;
    if (cyc !== 8 || len !== 7'd6) begin
      errors++; $display("FAIL grow_latency: cyc %0d len %0d, want cyc 8 len 6", cyc, len);
    end
  endtask

  task automatic test_reversal();
    int cyc, exp_cyc;
    do_restart();
    for (int s = 0; s < 4; s++) do_move(1, 1'b1, cyc, exp_cyc);
    do_move(3, 1'b0, cyc, exp_cyc);
    checks++;
    if (head_x !== 5'd21 || head_y !== 5'd12 || len !== 7'd5) begin
      errors++;
      $display("FAIL reversal_suppressed: (%0d,%0d) len %0d, want (21,12) len 5", head_x, head_y, len);
    end
    do_restart();
    do_move(3, 1'b0, cyc, exp_cyc);
    checks++;
    if (head_x !== 5'd15 || head_y !== 5'd12) begin
      errors++; $display("FAIL reversal_len1: (%0d,%0d), want (15,12)", head_x, head_y);
    end
  endtask

  task automatic test_collision();
    int cyc, exp_cyc;
    do_restart();
    for (int s = 0; s < 4; s++) do_move(1, 1'b1, cyc, exp_cyc);
    do_move(2, 1'b0, cyc, exp_cyc);
    do_move(3, 1'b0, cyc, exp_cyc);
    do_move(0, 1'b0, cyc, exp_cyc);
    checks++;
    if (cyc !== 8 || collide !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL collide_detect: cyc %0d collide %b busy %b, want 8 1 0", cyc, collide, busy);
    end
    checks++;
    if (head_x !== 5'd19 || head_y !== 5'd13 || len !== 7'd5) begin
      errors++;
      $display("FAIL collide_head: (%0d,%0d) len %0d, want (19,13) len 5", head_x, head_y, len);
    end
    do_move(1, 1'b0, cyc, exp_cyc);
    checks++;
    if (cyc !== -1 || collide !== 1'b1 || head_x !== 5'd19 || head_y !== 5'd13) begin
      errors++;
      $display("FAIL dead_ignore: cyc %0d collide %b (%0d,%0d), want -1 1 (19,13)",
               cyc, collide, head_x, head_y);
    end
    do_restart();
    checks++;
    if (collide !== 1'b0 || len !== 7'd1 || head_x !== 5'd16 || head_y !== 5'd12 ||
        rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL restart_state: collide %b len %0d (%0d,%0d) rd_valid %b, want 0 1 (16,12) 0",
               collide, len, head_x, head_y, rd_valid);
    end
  endtask

  task automatic test_back_to_back();
    int ndone;
    do_restart();
    for (int m = 0; m < 3; m++) model_move(1, 1'b0);
    @(negedge clk);
    dir = 2'd1; grow = 1'b0; step = 1'b1;
    ndone = 0;
    for (int p = 1; p <= 30; p++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        checks++;
        if (p !== 4 * ndone) begin
          errors++; $display("FAIL b2b_spacing: done %0d at cycle %0d, want %0d", ndone, p, 4 * ndone);
        end
        if (ndone == 3) step = 1'b0;
      end
    end
    step = 1'b0;
    checks++;
    if (ndone !== 3 || head_x !== mbody[$].x || head_y !== mbody[$].y) begin
      errors++;
      $display("FAIL b2b_moves: %0d dones head (%0d,%0d), want 3 dones (%0d,%0d)",
               ndone, head_x, head_y, mbody[$].x, mbody[$].y);
    end
  endtask

  task automatic test_max_len();
    int cyc, exp_cyc;
    int dseq[$];
    logic [4:0] x, y;
    logic v;
    do_restart();
    // Serpentine path of 63 distinct cells keeps the growing snake clear of itself.
    for (int i = 0; i < 15; i++) dseq.push_back(1);
    dseq.push_back(2);
    for (int i = 0; i < 31; i++) dseq.push_back(3);
    dseq.push_back(2);
    for (int i = 0; i < 15; i++) dseq.push_back(1);
    foreach (dseq[i]) begin
      do_move(dseq[i], 1'b1, cyc, exp_cyc);
      checks++;
      if (cyc !== exp_cyc || len !== 7'(mbody.size()) || collide !== 1'b0) begin
        errors++;
        $display("FAIL maxlen_build move %0d: cyc %0d len %0d collide %b, want cyc %0d len %0d 0",
                 i, cyc, len, collide, exp_cyc, mbody.size());
      end
    end
    do_move(1, 1'b1, cyc, exp_cyc);
    checks++;
    if (len !== 7'd64 || cyc !== 67 || head_x !== 5'd16 || head_y !== 5'd14) begin
      errors++;
      $display("FAIL maxlen_grow: len %0d cyc %0d head (%0d,%0d), want 64 67 (16,14)",
               len, cyc, head_x, head_y);
    end
    read_seg(0, x, y, v);
    checks++;
    if (v !== 1'b1 || x !== 5'd17 || y !== 5'd12) begin
      errors++; $display("FAIL maxlen_tail: v=%b (%0d,%0d), want 1 (17,12)", v, x, y);
    end
    read_seg(63, x, y, v);
    checks++;
    if (v !== 1'b1 || x !== 5'd16 || y !== 5'd14) begin
      errors++; $display("FAIL maxlen_head_rd: v=%b (%0d,%0d), want 1 (16,14)", v, x, y);
    end
  endtask

  task automatic test_random();
    int cyc, exp_cyc, d, i;
    bit g;
    logic [4:0] x, y;
    logic v;
    do_restart();
    for (int n = 0; n < 40; n++) begin
      d = int'($urandom_range(3));
      g = ($urandom_range(3) == 0);
      do_move(d, g, cyc, exp_cyc);
      checks++;
      if (cyc !== exp_cyc || collide !== mcol || len !== 7'(mbody.size()) ||
          head_x !== mbody[$].x || head_y !== mbody[$].y) begin
        errors++;
        $display("FAIL rand_move %0d: cyc %0d col %b len %0d (%0d,%0d), want %0d %b %0d (%0d,%0d)",
                 n, cyc, collide, len, head_x, head_y, exp_cyc, mcol, mbody.size(),
                 mbody[$].x, mbody[$].y);
      end
      i = int'($urandom_range(ML - 1));
      read_seg(i, x, y, v);
      checks++;
      if (i < mbody.size()) begin
        if (v !== 1'b1 || x !== mbody[i].x || y !== mbody[i].y) begin
          errors++;
          $display("FAIL rand_rd idx %0d: v=%b (%0d,%0d), want 1 (%0d,%0d)",
                   i, v, x, y, mbody[i].x, mbody[i].y);
        end
      end else if (v !== 1'b0 || x !== 5'd0 || y !== 5'd0) begin
        errors++; $display("FAIL rand_rd idx %0d: v=%b (%0d,%0d), want 0 (0,0)", i, v, x, y);
      end
      if (mcol) do_restart();
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_wrap();
    test_grow();
    test_reversal();
    test_collision();
    test_back_to_back();
    test_max_len();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
